// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared ISA constants for fetch, instruction memory and execute:
//   - instruction/address field widths
//   - opcode values that more than one block needs to agree on
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int ADDR_W  = 12;  // 4096-word instruction space
    localparam int INSTR_W = 18;  // {opcode[5:0], operand[11:0]}
    localparam int OPC_W   = 6;
    localparam int CNT_W   = 16;

    localparam logic [5:0] OPC_JPNZ  = 6'd24;
    localparam logic [5:0] OPC_NOP   = 6'd28;
    localparam logic [5:0] OPC_ENDOP = 6'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_VALID,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Fetch -> execute handshake bundle.
//   instr_valid / instr_ready : valid/ready handshake on the instruction
//   instr, opcode, operand    : instruction register and its two fields
//   instr_pc                  : address the instruction was fetched from
//   jump_en / jump_addr       : redirect request from execute (taken jpnz)
// master = fetch side, slave = execute side.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 18,
    parameter int OPC_W   = 6
);

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [OPC_W-1:0]   opcode;
    logic [ADDR_W-1:0]  operand;
    logic [ADDR_W-1:0]  instr_pc;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;

    modport master (
        output instr_valid, instr, opcode, operand, instr_pc,
        input  instr_ready, jump_en, jump_addr
    );

    modport slave (
        input  instr_valid, instr, opcode, operand, instr_pc,
        output instr_ready, jump_en, jump_addr
    );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of a registered instruction memory. Holds the PC,
// drives the memory read address, captures the returned word into the IR and
// offers it to execute over a valid/ready handshake. Execute may redirect the
// PC (taken jpnz); an accepted endop stops fetch until the next start pulse.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, begin fetching at PC 0 (from IDLE or HALT)
//   mem_addr    : instruction memory read address (the pc register)
//   mem_instr   : registered memory data, valid one cycle after mem_addr
//   fif         : handshake/redirect bundle to execute (master side)
//   busy        : fetch active (not IDLE, not HALT)
//   halted      : endop accepted, fetch stopped
//   retired     : saturating count of accepted instructions
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               ADDR_W    = instr_fetch_pkg::ADDR_W,
    parameter int               INSTR_W   = instr_fetch_pkg::INSTR_W,
    parameter int               OPC_W     = instr_fetch_pkg::OPC_W,
    parameter logic [OPC_W-1:0] OPC_ENDOP = instr_fetch_pkg::OPC_ENDOP,
    parameter int               CNT_W     = instr_fetch_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    instr_fetch_if.master      fif,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               accept;
    logic               jump_live;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;

        // A jump only counts while a fetch is in flight; IDLE/HALT ignore it.
        jump_live = fif.jump_en &&
                    (state_q == S_ADDR || state_q == S_CAPT || state_q == S_VALID);
        // A same-cycle jump squashes the handshake, so it never retires.
        accept    = (state_q == S_VALID) && fif.instr_ready && !fif.jump_en;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                // Memory output now reflects the address presented in ADDR.
                ir_d       = mem_instr;
                instr_pc_d = pc_q;
                pc_d       = pc_q + 1'b1;
                state_d    = S_VALID;
            end
            S_VALID: begin
                if (accept) begin
                    retired_d = sat_inc(retired_q);
                    state_d   = (ir_q[INSTR_W-1 -: OPC_W] == OPC_ENDOP) ? S_HALT : S_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (jump_live) begin
            pc_d       = fif.jump_addr;
            ir_d       = ir_q;
            instr_pc_d = instr_pc_q;
            state_d    = S_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_pc_q <= '0;
            ir_q       <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
        end
    end

    assign mem_addr        = pc_q;
    assign fif.instr_valid = (state_q == S_VALID);
    assign fif.instr       = ir_q;
    assign fif.opcode      = ir_q[INSTR_W-1 -: OPC_W];
    assign fif.operand     = ir_q[ADDR_W-1:0];
    assign fif.instr_pc    = instr_pc_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted          = (state_q == S_HALT);
    assign retired         = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a registered instruction memory model.
// Scenarios run in sequence, each continuing from the state the previous left.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] mem_addr;
    logic [17:0] mem_instr = '0;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [17:0] mem [4096];

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_if fif ();

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_instr (mem_instr),
        .fif       (fif),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_instr <= mem[mem_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        fif.instr_ready = 1'b0; fif.jump_en = 1'b0; fif.jump_addr = '0;
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b0) begin $display("FAIL reset_valid got %0b want 0", fif.instr_valid); n_bad++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0b want 0", busy); n_bad++; end
        n_cmp++; if (halted !== 1'b0) begin $display("FAIL reset_halted got %0b want 0", halted); n_bad++; end
        n_cmp++; if (retired !== 16'd0) begin $display("FAIL reset_retired got %0d want 0", retired); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd0) begin $display("FAIL reset_mem_addr got %0d want 0", mem_addr); n_bad++; end
        n_cmp++; if (fif.instr !== 18'd0) begin $display("FAIL reset_instr got %0h want 0", fif.instr); n_bad++; end
        n_cmp++; if (fif.instr_pc !== 12'd0) begin $display("FAIL reset_instr_pc got %0d want 0", fif.instr_pc); n_bad++; end
        rst = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL idle_no_start_busy got %0b want 0", busy); n_bad++; end
    endtask

    // NOPs at 0..2, ready held high: valid on cycles 3, 6, 9 after start.
    task automatic test_back_to_back;
        fif.instr_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int t = 1; t <= 3; t++) begin
                tick;
                if (k == 0 && t == 1) begin
                    start = 1'b0;
                    n_cmp++; if (busy !== 1'b1) begin $display("FAIL b2b_busy got %0b want 1", busy); n_bad++; end
                end
                if (t < 3) begin
                    n_cmp++; if (fif.instr_valid !== 1'b0) begin $display("FAIL b2b_early_valid k=%0d t=%0d got 1 want 0", k, t); n_bad++; end
                end else begin
                    n_cmp++; if (fif.instr_valid !== 1'b1) begin $display("FAIL b2b_valid k=%0d got 0 want 1", k); n_bad++; end
                    n_cmp++; if (fif.instr_pc !== 12'(k)) begin $display("FAIL b2b_instr_pc got %0d want %0d", fif.instr_pc, k); n_bad++; end
                    n_cmp++; if (fif.opcode !== 6'd28) begin $display("FAIL b2b_opcode got %0d want 28", fif.opcode); n_bad++; end
                    n_cmp++; if (fif.operand !== 12'(12'h00A + k)) begin $display("FAIL b2b_operand got %0h want %0h", fif.operand, 12'h00A + k); n_bad++; end
                end
            end
        end
        tick;
        n_cmp++; if (retired !== 16'd3) begin $display("FAIL b2b_retired got %0d want 3", retired); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd3) begin $display("FAIL b2b_next_addr got %0d want 3", mem_addr); n_bad++; end
    endtask

    // Stall 10 cycles in VALID at addr 3; a start pulse meanwhile is ignored.
    task automatic test_stall;
        fif.instr_ready = 1'b0;
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd3 || fif.instr !== 18'h01123)
            begin $display("FAIL stall_entry got v=%0b pc=%0d ir=%0h want v=1 pc=3 ir=1123", fif.instr_valid, fif.instr_pc, fif.instr); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd4) begin $display("FAIL stall_mem_addr got %0d want 4", mem_addr); n_bad++; end
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            start = 1'b0;
            n_cmp++;
            if (fif.instr_valid !== 1'b1 || fif.instr !== 18'h01123 || fif.instr_pc !== 12'd3 ||
                mem_addr !== 12'd4 || retired !== 16'd3) begin
                $display("FAIL stall_hold cyc=%0d got v=%0b ir=%0h pc=%0d addr=%0d ret=%0d want v=1 ir=1123 pc=3 addr=4 ret=3",
                         i, fif.instr_valid, fif.instr, fif.instr_pc, mem_addr, retired);
                n_bad++;
            end
        end
        fif.instr_ready = 1'b1;
        tick;
        n_cmp++; if (retired !== 16'd4) begin $display("FAIL stall_accept_retired got %0d want 4", retired); n_bad++; end
        n_cmp++; if (fif.instr_valid !== 1'b0) begin $display("FAIL stall_accept_valid got %0b want 0", fif.instr_valid); n_bad++; end
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd4)
            begin $display("FAIL stall_resume got v=%0b pc=%0d want v=1 pc=4", fif.instr_valid, fif.instr_pc); n_bad++; end
    endtask

    // JPNZ at 5 accepted; redirect to 51 while addr 6 is being captured.
    task automatic test_jump_capt;
        tick; tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd5 || fif.opcode !== 6'd24 || fif.operand !== 12'd51)
            begin $display("FAIL jpnz_fetch got v=%0b pc=%0d opc=%0d opr=%0d want v=1 pc=5 opc=24 opr=51", fif.instr_valid, fif.instr_pc, fif.opcode, fif.operand); n_bad++; end
        tick;
        n_cmp++; if (retired !== 16'd6) begin $display("FAIL jpnz_retired got %0d want 6", retired); n_bad++; end
        tick;
        n_cmp++; if (mem_addr !== 12'd6) begin $display("FAIL capt_addr got %0d want 6", mem_addr); n_bad++; end
        fif.jump_en = 1'b1; fif.jump_addr = 12'd51;
        tick;
        fif.jump_en = 1'b0;
        n_cmp++; if (fif.instr_valid !== 1'b0 || mem_addr !== 12'd51)
            begin $display("FAIL jump_capt_redirect got v=%0b addr=%0d want v=0 addr=51", fif.instr_valid, mem_addr); n_bad++; end
        tick;
        n_cmp++; if (fif.instr_valid !== 1'b0) begin $display("FAIL jump_capt_squash got 1 want 0"); n_bad++; end
        tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd51 || fif.instr !== 18'h02051)
            begin $display("FAIL jump_target got v=%0b pc=%0d ir=%0h want v=1 pc=51 ir=2051", fif.instr_valid, fif.instr_pc, fif.instr); n_bad++; end
    endtask

    // Jump and ready together in VALID: jump wins, nothing retires.
    task automatic test_jump_beats_ready;
        fif.instr_ready = 1'b1; fif.jump_en = 1'b1; fif.jump_addr = 12'd157;
        tick;
        fif.jump_en = 1'b0;
        n_cmp++; if (retired !== 16'd6) begin $display("FAIL jump_ready_retired got %0d want 6", retired); n_bad++; end
        n_cmp++; if (fif.instr_valid !== 1'b0 || mem_addr !== 12'd157)
            begin $display("FAIL jump_ready_redirect got v=%0b addr=%0d want v=0 addr=157", fif.instr_valid, mem_addr); n_bad++; end
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd157 || fif.opcode !== 6'd31)
            begin $display("FAIL endop_fetch got v=%0b pc=%0d opc=%0d want v=1 pc=157 opc=31", fif.instr_valid, fif.instr_pc, fif.opcode); n_bad++; end
    endtask

    // Endop accept -> HALT; jump ignored; start restarts from 0.
    task automatic test_endop_halt;
        tick;
        n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || fif.instr_valid !== 1'b0)
            begin $display("FAIL halt_flags got h=%0b b=%0b v=%0b want h=1 b=0 v=0", halted, busy, fif.instr_valid); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd158) begin $display("FAIL halt_mem_addr got %0d want 158", mem_addr); n_bad++; end
        n_cmp++; if (retired !== 16'd7) begin $display("FAIL halt_retired got %0d want 7", retired); n_bad++; end
        fif.jump_en = 1'b1; fif.jump_addr = 12'd9;
        tick; tick;
        fif.jump_en = 1'b0;
        n_cmp++; if (halted !== 1'b1 || mem_addr !== 12'd158)
            begin $display("FAIL halt_jump_ignored got h=%0b addr=%0d want h=1 addr=158", halted, mem_addr); n_bad++; end
        fif.instr_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++; if (halted !== 1'b0 || busy !== 1'b1 || mem_addr !== 12'd0)
            begin $display("FAIL restart got h=%0b b=%0b addr=%0d want h=0 b=1 addr=0", halted, busy, mem_addr); n_bad++; end
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd0 || retired !== 16'd7)
            begin $display("FAIL restart_fetch got v=%0b pc=%0d ret=%0d want v=1 pc=0 ret=7", fif.instr_valid, fif.instr_pc, retired); n_bad++; end
    endtask

    // PC wraps 4095 -> 0; reset during CAPT clears everything.
    task automatic test_wrap_and_reset;
        fif.jump_en = 1'b1; fif.jump_addr = 12'd4095;
        tick;
        fif.jump_en = 1'b0;
        n_cmp++; if (mem_addr !== 12'd4095) begin $display("FAIL wrap_jump_addr got %0d want 4095", mem_addr); n_bad++; end
        tick; tick;
        n_cmp++; if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 12'd4095 || fif.instr !== 18'h03FFF)
            begin $display("FAIL wrap_fetch got v=%0b pc=%0d ir=%0h want v=1 pc=4095 ir=3fff", fif.instr_valid, fif.instr_pc, fif.instr); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd0) begin $display("FAIL wrap_mem_addr got %0d want 0", mem_addr); n_bad++; end
        fif.instr_ready = 1'b1;
        tick;
        n_cmp++; if (retired !== 16'd8) begin $display("FAIL wrap_retired got %0d want 8", retired); n_bad++; end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++; if (busy !== 1'b0 || fif.instr_valid !== 1'b0 || halted !== 1'b0)
            begin $display("FAIL midrst_flags got b=%0b v=%0b h=%0b want 0 0 0", busy, fif.instr_valid, halted); n_bad++; end
        n_cmp++; if (mem_addr !== 12'd0 || retired !== 16'd0 || fif.instr !== 18'd0 || fif.instr_pc !== 12'd0)
            begin $display("FAIL midrst_regs got addr=%0d ret=%0d ir=%0h pc=%0d want all 0", mem_addr, retired, fif.instr, fif.instr_pc); n_bad++; end
        rst = 1'b0;
        fif.instr_ready = 1'b0;
        fif.jump_en = 1'b1; fif.jump_addr = 12'd77;
        tick;
        fif.jump_en = 1'b0;
        n_cmp++; if (mem_addr !== 12'd0 || busy !== 1'b0)
            begin $display("FAIL idle_jump_ignored got addr=%0d b=%0b want addr=0 b=0", mem_addr, busy); n_bad++; end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 18'd0;
        mem[0]    = {6'd28, 12'h00A};
        mem[1]    = {6'd28, 12'h00B};
        mem[2]    = {6'd28, 12'h00C};
        mem[3]    = {6'd1,  12'h123};
        mem[4]    = {6'd28, 12'h004};
        mem[5]    = {6'd24, 12'd51};
        mem[6]    = {6'd5,  12'h666};
        mem[51]   = {6'd2,  12'h051};
        mem[157]  = {6'd31, 12'h000};
        mem[4095] = {6'd3,  12'hFFF};

        test_reset;
        test_back_to_back;
        test_stall;
        test_jump_capt;
        test_jump_beats_ready;
        test_endop_halt;
        test_wrap_and_reset;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Holds the program counter (PC) and drives the memory read address.
- Captures the registered 18-bit instruction ({opcode[5:0], operand[11:0]}) one cycle later and presents it to the control/execute unit over a valid/ready handshake.
- Handles jpnz redirects from execute and stops on endop.

Parameters:
- ADDR_W, 12, PC / instruction-memory address width (4096 words).
- INSTR_W, 18, instruction word width.
- OPC_W, 6, opcode field width (instr[17:12]).
- OPC_ENDOP, 31, opcode that halts fetch once accepted.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin fetching at PC 0
- mem_addr  out  ADDR_W  read address to instruction memory (= pc register)
- mem_instr  in  INSTR_W  registered instruction memory output, valid one cycle after mem_addr
- instr_valid  out  1  instr/opcode/operand outputs hold a fetched instruction
- instr_ready  in  1  execute accepts the instruction this cycle
- instr  out  INSTR_W  instruction register (IR)
- opcode  out  OPC_W  IR[17:12]
- operand  out  ADDR_W  IR[11:0]
- instr_pc  out  ADDR_W  address the IR was fetched from
- jump_en  in  1  redirect request from execute (taken jpnz)
- jump_addr  in  ADDR_W  redirect target
- busy  out  1  state is not IDLE and not HALT
- halted  out  1  endop accepted; fetch stopped
- retired  out  CNT_W  count of accepted instructions, saturating

Behaviour:
- Reset values:
  - state=IDLE, pc=0, instr=0, instr_pc=0, retired=0.
  - instr_valid=0, busy=0, halted=0.
- States: IDLE, ADDR, CAPT, VALID, HALT.
- IDLE:
  - start=1 -> pc<=0, go ADDR.
  - All other inputs are ignored.
- ADDR:
  - mem_addr=pc is presented to memory; go CAPT.
- CAPT:
  - mem_instr now corresponds to pc.
  - IR<=mem_instr, instr_pc<=pc, pc<=pc+1 (wraps 4095->0, no flag), go VALID.
- VALID:
  - instr_valid=1; IR is held stable while not accepted (instr_ready=0 stalls indefinitely).
  - accept = instr_valid & instr_ready & ~jump_en.
  - On accept: retired<=retired+1, saturating at all-ones.
  - On accept with opcode==OPC_ENDOP: go HALT. Otherwise go ADDR.
- Latency:
  - start (cycle 0) -> instr_valid high at cycle 3.
  - Back-to-back with instr_ready=1: one instruction per 3 cycles.
- Redirect:
  - jump_en=1 in ADDR, CAPT or VALID has priority over every other transition.
  - pc<=jump_addr, go ADDR; any IR contents are discarded and instr_valid drops the next cycle.
  - jump_en and instr_ready both high in the same VALID cycle: the jump wins and the instruction is NOT counted as accepted.
  - jump_en in IDLE or HALT is ignored.
- HALT:
  - halted=1, instr_valid=0, pc frozen.
  - start=1 -> pc<=0, halted<=0, go ADDR; retired is kept.
- start while busy is ignored.
- rst mid-operation (any state) -> full reset values next cycle; no partial instruction is ever presented.
- opcode and operand are pure slices of IR; no decoding beyond the endop compare.
- mem_addr is driven combinationally from the pc register (no extra latency).

Decomposition:
- Shared package: ISA constants (INSTR_W, OPC_W, ADDR_W), the opcode localparams (ENDOP=31, JPNZ=24, NOP=28, etc., the same values used by instruction memory and execute), and the fetch state encoding.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset then start; memory holds NOP at addrs 0..2, instr_ready=1 -> instr_valid at cycles 3, 6, 9 with instr_pc 0, 1, 2 and opcode 28; retired=3 after the third accept.
- Hold instr_ready=0 for 10 cycles in VALID -> IR, instr_pc and mem_addr stable, retired unchanged; instr_ready=1 -> single accept, fetch resumes at pc+1.
- Accept JPNZ at addr 5, then pulse jump_en with jump_addr=51 while CAPT holds addr 6 -> addr 6 instruction never valid; next instr_pc=51.
- jump_en and instr_ready both high in VALID -> retired not incremented, next instr_pc=jump_addr.
- ENDOP at addr 157 accepted -> halted=1, busy=0, instr_valid=0, mem_addr frozen at 158; jump_en ignored; start -> refetch from addr 0.
- pc=4095 fetch -> next mem_addr=0; rst asserted during CAPT -> next cycle state IDLE, pc=0, instr_valid=0, retired=0.
